traffic_request_latch: RTL and testbench
========================================

// Module: traffic_request_latch
// PURPOSE
//  Input-side front end for the intersection controller. It conditions the two pedestrian
//  buttons and four car sensors: 2-flop sync, debounce, presence dwell. It latches each
//  qualified event as a pending request and holds it until the controller reports that
//  request's phase green. The controller consumes the pending vector for early phase advance.
//  Request index map (fixed):
//   0 straight-street ped button   -> served by phase 0 (straight street straight lane)
//   1 cross-street ped button      -> served by phase 2 (cross street straight lane)
//   2 straight-street straight car -> phase 0
//   3 straight-street turn car     -> phase 1
//   4 cross-street straight car    -> phase 2
//   5 cross-street turn car        -> phase 3
// PARAMETERS
//  DEBOUNCE_CYCLES  20   consecutive stable clk cycles before debounced level changes (>=1)
//  CAR_DWELL_CYCLES 2000 clk cycles a car sensor must stay debounced-high before latching (>=1)
//  CNT_W            12   width of debounce/dwell counters; must hold max(params)
// PORTS
//  clk           in   1  system clock, 1 kHz nominal
//  reset         in   1  synchronous, active-high reset
//  raw_in        in   6  asynchronous button/sensor levels, bit order per index map
//  phase         in   2  controller's current state encoding (0..3)
//  phase_green   in   1  1 while the current phase's green/walk is lit
//  pending       out  6  latched requests, bit order per index map
//  pending_any   out  1  OR of pending
//  new_req       out  1  one-cycle pulse on any pending bit 0->1 transition
//  debounced     out  6  debounced levels, for status/visibility
// BEHAVIOUR
//  Interface: one clock, clk; reset is synchronous and active-high.
//  Reset: all outputs 0; sync flops, debounced state, counters and pending all cleared.
//   Reset asserted mid-debounce or mid-dwell discards progress. The first post-reset
//   evaluation starts from the cleared state.
//  Sync: s1 <= raw_in; s2 <= s1. Per bit, no cross-bit interaction.
//  Debounce (per bit):
//   - If s2 == db, cnt <= 0.
//   - Else if cnt == DEBOUNCE_CYCLES-1, db <= s2 and cnt <= 0.
//   - Else cnt <= cnt+1.
//   - A raw change held stable is reflected on debounced DEBOUNCE_CYCLES+2 edges after it is
//     first sampled. Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 is ignored.
//  served[i] = phase_green && (phase == map[i]). This is combinational from the inputs.
//  Buttons (bits 0,1):
//   - set when db rises (db & ~db_q) and !served[i].
//   - clear when served[i]; clear has priority over set.
//   - A press while its phase is already green is dropped.
//   - A press while already pending causes no change and no new_req.
//  Cars (bits 2..5):
//   - dwell <= 0 when !db | served[i] | pending[i]; otherwise dwell <= dwell+1 (saturates).
//   - set when dwell == CAR_DWELL_CYCLES-1 and db is still high.
//   - clear when served[i]; clear has priority.
//   - A sensor dropping before dwell completes latches nothing.
//  Pending is registered; latency from set condition to pending high is 1 edge.
//   pending_any is combinational from pending.
//  new_req <= |(pending_next & ~pending). Simultaneous sets produce a single pulse.
//  Phase change with phase_green=0 clears nothing. Requests survive yellow/red intervals.
//  phase values are all legal; there is no illegal-state handling.
// TESTING (bench params DEBOUNCE_CYCLES=4, CAR_DWELL_CYCLES=8)
//  1 reset held 3 cycles with raw_in=6'h3F -> pending=0, debounced=0, new_req=0 during reset.
//  2 raw_in[0] pulsed high 3 cycles, phase=2 -> debounced[0] stays 0, pending[0] stays 0.
//  3 raw_in[0] held high, phase=2, phase_green=1
//    -> debounced[0] rises after 6 edges; pending[0]=1 next edge; new_req pulses exactly 1 cycle.
//    Then phase=0, phase_green=1 -> pending[0] clears next edge.
//  4 raw_in[5] high 7 cycles after debounce, then low -> no latch.
//    raw_in[5] held high -> pending[5]=1 after 8 dwell cycles.
//    phase=3, phase_green=0 -> pending[5] holds; phase_green=1 -> pending[5] clears.
//  5 phase=0, phase_green=1, press raw_in[0] and hold raw_in[2] -> neither latches.
//    Drop phase_green -> pending[2] latches after 8 dwell cycles; pending[0] does not.
//  6 bits 1 and 4 qualify on the same edge -> pending=6'h12, one new_req pulse.
//    Assert reset mid-dwell on bit 3 -> dwell restarts from 0 after reset.

Source files
------------

// File: rtl/traffic_request_latch.sv
// Intersection input front end: sync, debounce and car dwell
// qualification; latches requests until their phase is green.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   raw_in[5:0]  async buttons (0,1) and car sensors (2..5)
//   phase[1:0]   controller's current phase
//   phase_green  high while current phase green/walk is lit
//   pending[5:0] latched requests
//   pending_any  OR of pending
//   new_req      one-cycle pulse when any pending bit sets
//   debounced    debounced input levels
module traffic_request_latch #(
  parameter int DEBOUNCE_CYCLES  = 20,
  parameter int CAR_DWELL_CYCLES = 2000,
  parameter int CNT_W            = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] raw_in,
  input  logic [1:0] phase,
  input  logic       phase_green,
  output logic [5:0] pending,
  output logic       pending_any,
  output logic       new_req,
  output logic [5:0] debounced
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DW_LAST =
    CNT_W'(CAR_DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DW_MAX = '1;

  // Serving phase of each request, index 5 in the top pair.
  localparam logic [11:0] PHASE_MAP =
    {2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd0};

  logic [5:0]       s1_q, s1_d;
  logic [5:0]       s2_q, s2_d;
  logic [5:0]       db_q, db_d;
  logic [5:0]       dbp_q, dbp_d;
  logic [5:0]       pend_q, pend_d;
  logic             nreq_q, nreq_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic [CNT_W-1:0] dwell_q [4];
  logic [CNT_W-1:0] dwell_d [4];
  logic [5:0]       served;

  always_comb begin
    served = '0;
    for (int i = 0; i < 6; i++) begin
      served[i] = phase_green &&
        (phase == PHASE_MAP[2*i +: 2]);
    end
  end

  always_comb begin
    s1_d   = raw_in;
    s2_d   = s1_q;
    db_d   = db_q;
    dbp_d  = db_q;
    pend_d = pend_q;

    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // Buttons latch on the debounced rising edge only.
    for (int i = 0; i < 2; i++) begin
      if (served[i]) begin
        pend_d[i] = 1'b0;
      end else if (db_q[i] && !dbp_q[i]) begin
        pend_d[i] = 1'b1;
      end
    end

    // Cars need a sustained presence; the dwell timer
    // idles while served or already pending.
    for (int j = 0; j < 4; j++) begin
      dwell_d[j] = dwell_q[j];
      if (!db_q[j+2] || served[j+2] || pend_q[j+2]) begin
        dwell_d[j] = '0;
      end else if (dwell_q[j] != DW_MAX) begin
        dwell_d[j] = dwell_q[j] + CNT_W'(1);
      end
      if (served[j+2]) begin
        pend_d[j+2] = 1'b0;
      end else if (db_q[j+2] && dwell_q[j] == DW_LAST) begin
        pend_d[j+2] = 1'b1;
      end
    end

    nreq_d = |(pend_d & ~pend_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      dbp_q  <= '0;
      pend_q <= '0;
      nreq_q <= 1'b0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      for (int j = 0; j < 4; j++) dwell_q[j] <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      db_q   <= db_d;
      dbp_q  <= dbp_d;
      pend_q <= pend_d;
      nreq_q <= nreq_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      for (int j = 0; j < 4; j++) dwell_q[j] <= dwell_d[j];
    end
  end

  assign pending     = pend_q;
  assign pending_any = |pend_q;
  assign new_req     = nreq_q;
  assign debounced   = db_q;

endmodule

// File: tb/tb_traffic_request_latch.sv
// Bench for traffic_request_latch: scripted stimulus with
// per-cycle expectations queued and checked after each edge.
module tb_traffic_request_latch;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] raw_in;
  logic [1:0] phase;
  logic       phase_green;
  logic [5:0] pending;
  logic       pending_any;
  logic       new_req;
  logic [5:0] debounced;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [5:0] pend;
    logic       nreq;
    logic [5:0] db;
    logic [5:0] dbm;
  } exp_t;

  exp_t sb_q[$];

  traffic_request_latch #(
    .DEBOUNCE_CYCLES (4),
    .CAR_DWELL_CYCLES(8),
    .CNT_W           (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .phase      (phase),
    .phase_green(phase_green),
    .pending    (pending),
    .pending_any(pending_any),
    .new_req    (new_req),
    .debounced  (debounced)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_pend"}, 32'(pending), 32'(e.pend));
      chk({e.tag, "_any"}, 32'(pending_any),
          32'(|e.pend));
      chk({e.tag, "_nreq"}, 32'(new_req), 32'(e.nreq));
      chk({e.tag, "_db"}, 32'(debounced & e.dbm),
          32'(e.db & e.dbm));
    end
  endtask

  task automatic cyc(string tag, logic [5:0] pend,
                     logic nreq, logic [5:0] db,
                     logic [5:0] dbm);
    exp_t e;
    e.tag  = tag;
    e.pend = pend;
    e.nreq = nreq;
    e.db   = db;
    e.dbm  = dbm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_chk();
  endtask

  task automatic cycs(int n, string tag, logic [5:0] pend,
                      logic nreq, logic [5:0] db,
                      logic [5:0] dbm);
    for (int k = 0; k < n; k++) cyc(tag, pend, nreq, db, dbm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    raw_in      = 6'h3F;
    phase       = 2'd0;
    phase_green = 1'b0;
    cycs(3, "rst", 6'h00, 0, 6'h00, 6'h3F);

    reset  = 1'b0;
    raw_in = 6'h00;
    cycs(4, "idle", 6'h00, 0, 6'h00, 6'h3F);

    // short glitch on button 0
    phase  = 2'd2;
    raw_in = 6'h01;
    cycs(3, "glitch_hi", 6'h00, 0, 6'h00, 6'h3F);
    raw_in = 6'h00;
    cycs(10, "glitch_lo", 6'h00, 0, 6'h00, 6'h3F);

    // held press, latch, then serve
    phase_green = 1'b1;
    raw_in      = 6'h01;
    cycs(5, "b0_pre", 6'h00, 0, 6'h00, 6'h3F);
    cyc("b0_db", 6'h00, 0, 6'h01, 6'h3F);
    cyc("b0_set", 6'h01, 1, 6'h01, 6'h3F);
    cyc("b0_hold", 6'h01, 0, 6'h01, 6'h3F);
    phase = 2'd0;
    cyc("b0_clr", 6'h00, 0, 6'h01, 6'h3F);
    raw_in = 6'h00;
    cycs(5, "b0_rel", 6'h00, 0, 6'h01, 6'h3F);
    cycs(3, "b0_low", 6'h00, 0, 6'h00, 6'h3F);
    phase_green = 1'b0;

    // car 5: one cycle short of dwell
    raw_in = 6'h20;
    cycs(5, "c5s_pre", 6'h00, 0, 6'h00, 6'h3F);
    cycs(2, "c5s_db", 6'h00, 0, 6'h20, 6'h3F);
    raw_in = 6'h00;
    cycs(5, "c5s_fall", 6'h00, 0, 6'h20, 6'h3F);
    cycs(8, "c5s_none", 6'h00, 0, 6'h00, 6'h3F);

    // car 5: full dwell
    raw_in = 6'h20;
    cycs(5, "c5_pre", 6'h00, 0, 6'h00, 6'h3F);
    cycs(8, "c5_dwell", 6'h00, 0, 6'h20, 6'h3F);
    cyc("c5_set", 6'h20, 1, 6'h20, 6'h3F);
    phase = 2'd3;
    cycs(4, "c5_red", 6'h20, 0, 6'h20, 6'h3F);
    phase_green = 1'b1;
    cyc("c5_clr", 6'h00, 0, 6'h20, 6'h3F);
    raw_in = 6'h00;
    cycs(5, "c5_rel", 6'h00, 0, 6'h20, 6'h3F);
    cycs(3, "c5_low", 6'h00, 0, 6'h00, 6'h3F);
    phase_green = 1'b0;
    phase       = 2'd0;

    // requests made during their own green
    phase_green = 1'b1;
    raw_in      = 6'h05;
    cycs(5, "g_pre", 6'h00, 0, 6'h00, 6'h3F);
    cycs(6, "g_drop", 6'h00, 0, 6'h05, 6'h3F);
    raw_in      = 6'h04;
    phase_green = 1'b0;
    cycs(5, "c2_dw", 6'h00, 0, 6'h04, 6'h04);
    cycs(2, "c2_dw2", 6'h00, 0, 6'h04, 6'h3F);
    cyc("c2_set", 6'h04, 1, 6'h04, 6'h3F);
    phase_green = 1'b1;
    cyc("c2_clr", 6'h00, 0, 6'h04, 6'h3F);
    raw_in = 6'h00;
    cycs(5, "c2_rel", 6'h00, 0, 6'h04, 6'h3F);
    cycs(3, "c2_low", 6'h00, 0, 6'h00, 6'h3F);
    phase_green = 1'b0;

    // simultaneous sets on bits 1 and 4
    raw_in = 6'h10;
    cycs(5, "sim_pre", 6'h00, 0, 6'h00, 6'h3F);
    cycs(2, "sim_c4", 6'h00, 0, 6'h10, 6'h3F);
    raw_in = 6'h12;
    cycs(5, "sim_b1", 6'h00, 0, 6'h10, 6'h3F);
    cyc("sim_db", 6'h00, 0, 6'h12, 6'h3F);
    cyc("sim_set", 6'h12, 1, 6'h12, 6'h3F);
    cyc("sim_hold", 6'h12, 0, 6'h12, 6'h3F);
    phase       = 2'd2;
    phase_green = 1'b1;
    cyc("sim_clr", 6'h00, 0, 6'h12, 6'h3F);
    raw_in = 6'h00;
    cycs(5, "sim_rel", 6'h00, 0, 6'h12, 6'h3F);
    cycs(3, "sim_low", 6'h00, 0, 6'h00, 6'h3F);
    phase_green = 1'b0;
    phase       = 2'd0;

    // reset in the middle of car 3 dwell
    raw_in = 6'h08;
    cycs(5, "c3_pre", 6'h00, 0, 6'h00, 6'h3F);
    cycs(5, "c3_dwell", 6'h00, 0, 6'h08, 6'h3F);
    reset = 1'b1;
    cycs(2, "c3_rst", 6'h00, 0, 6'h00, 6'h3F);
    reset = 1'b0;
    cycs(5, "c3_re", 6'h00, 0, 6'h00, 6'h3F);
    cycs(8, "c3_redw", 6'h00, 0, 6'h08, 6'h3F);
    cyc("c3_set", 6'h08, 1, 6'h08, 6'h3F);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
